// File: rtl/video_timing_pkg.sv
// video_timing_pkg: shared definitions for the video timing generator.
//   - axis_timing_t : visible/front/sync/back bundle describing one axis
//   - H_640X480 / V_640X480 and sync polarities for 640x480@60
//   - state_t       : generator run state (IDLE, RUN, STOPPING)
//   - axis_total    : total length of one axis
//   - cnt_width     : counter width able to hold 0..total-1
package video_timing_pkg;

    typedef struct packed {
        int unsigned visible;
        int unsigned front;
        int unsigned sync;
        int unsigned back;
    } axis_timing_t;

    localparam axis_timing_t H_640X480 = '{visible: 640, front: 16, sync: 96, back: 48};
    localparam axis_timing_t V_640X480 = '{visible: 480, front: 10, sync: 2,  back: 33};
    localparam logic         HSYNC_POL_640X480 = 1'b0;
    localparam logic         VSYNC_POL_640X480 = 1'b0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    function automatic int unsigned axis_total(input axis_timing_t t);
        return t.visible + t.front + t.sync + t.back;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

endpackage

// File: rtl/video_sync_counter.sv
// video_sync_counter: one timing axis (horizontal or vertical).
// A position counter that wraps at TOTAL-1, plus combinational decode of
// the visible region, the sync pulse level and the last position.
// Ports:
//   clk, reset_n  clock, synchronous active-low reset
//   clear         force the counter to 0
//   step          advance the counter by one position (wraps)
//   cnt           registered position
//   last_c        cnt == TOTAL-1
//   visible_c     cnt < VISIBLE
//   sync_c        POL inside the sync pulse, ~POL elsewhere
module video_sync_counter
    import video_timing_pkg::*;
#(
    parameter int unsigned VISIBLE   = H_640X480.visible,
    parameter int unsigned FRONT     = H_640X480.front,
    parameter int unsigned SYNC      = H_640X480.sync,
    parameter int unsigned BACK      = H_640X480.back,
    parameter logic        POL       = 1'b0,
    parameter int unsigned CNT_WIDTH = cnt_width(VISIBLE + FRONT + SYNC + BACK)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic                 step,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic                 last_c,
    output logic                 visible_c,
    output logic                 sync_c
);

    localparam axis_timing_t AXIS       = '{visible: VISIBLE, front: FRONT, sync: SYNC, back: BACK};
    localparam int unsigned  TOTAL      = axis_total(AXIS);
    localparam int unsigned  SYNC_START = VISIBLE + FRONT;
    localparam int unsigned  SYNC_END   = VISIBLE + FRONT + SYNC;

    // Decodes compare at 32 bits so a limit equal to 2**CNT_WIDTH cannot alias.
    logic [31:0] cnt_ext;
    assign cnt_ext = 32'(cnt);

    assign last_c    = (cnt_ext == TOTAL - 1);
    assign visible_c = (cnt_ext < VISIBLE);
    assign sync_c    = ((cnt_ext >= SYNC_START) && (cnt_ext < SYNC_END)) ? POL : ~POL;

    // Position counter
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            cnt <= '0;
        end else if (step) begin
            cnt <= last_c ? '0 : cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: video sync/coordinate source for the draw pipeline.
// Generates registered hsync/vsync/de, visible x/y and stream-style
// frame-start (tuser) / line-end (tlast) markers. Starts and stops only on
// frame boundaries; a stop always completes the current frame.
// Optional build macro: VIDEO_TIMING_GEN_FRAME_CNT_EN adds out_frame_cnt.
// Ports:
//   clk            pixel clock
//   reset_n        synchronous active-low reset
//   enable         run request, sampled every cycle
//   busy           generator not idle
//   out_vsync      vertical sync
//   out_hsync      horizontal sync
//   out_de         data enable (visible region)
//   out_x, out_y   visible coordinates, 0 outside de
//   out_fs         frame start, de at (0,0)
//   out_le         line end, de at x = H_VISIBLE-1
//   out_frame_cnt  frames started, modulo 2**16 (macro builds only)
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned H_VISIBLE = H_640X480.visible,
    parameter int unsigned H_FRONT   = H_640X480.front,
    parameter int unsigned H_SYNC    = H_640X480.sync,
    parameter int unsigned H_BACK    = H_640X480.back,
    parameter int unsigned V_VISIBLE = V_640X480.visible,
    parameter int unsigned V_FRONT   = V_640X480.front,
    parameter int unsigned V_SYNC    = V_640X480.sync,
    parameter int unsigned V_BACK    = V_640X480.back,
    parameter logic        HSYNC_POL = HSYNC_POL_640X480,
    parameter logic        VSYNC_POL = VSYNC_POL_640X480,
    parameter int unsigned X_WIDTH   = $clog2(H_VISIBLE),
    parameter int unsigned Y_WIDTH   = $clog2(V_VISIBLE)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    output logic               busy,
    output logic               out_vsync,
    output logic               out_hsync,
    output logic               out_de,
    output logic [X_WIDTH-1:0] out_x,
    output logic [Y_WIDTH-1:0] out_y,
    output logic               out_fs,
    output logic               out_le
`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
    ,
    output logic [15:0]        out_frame_cnt
`endif
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned H_CW    = cnt_width(H_TOTAL);
    localparam int unsigned V_CW    = cnt_width(V_TOTAL);

    state_t          state;
    logic            active;     // counters hold a live frame position
    logic [H_CW-1:0] h_cnt;
    logic [V_CW-1:0] v_cnt;
    logic            h_last_c;
    logic            h_vis_c;
    logic            h_sync_c;
    logic            v_last_c;
    logic            v_vis_c;
    logic            v_sync_c;
    logic            frame_end_c;
    logic            de_c;
    logic            fs_c;
    logic            le_c;

    // Horizontal axis: steps every live cycle
    video_sync_counter #(
        .VISIBLE   (H_VISIBLE),
        .FRONT     (H_FRONT),
        .SYNC      (H_SYNC),
        .BACK      (H_BACK),
        .POL       (HSYNC_POL),
        .CNT_WIDTH (H_CW)
    ) u_h_axis (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (!active),
        .step      (active),
        .cnt       (h_cnt),
        .last_c    (h_last_c),
        .visible_c (h_vis_c),
        .sync_c    (h_sync_c)
    );

    // Vertical axis: steps on each horizontal wrap
    video_sync_counter #(
        .VISIBLE   (V_VISIBLE),
        .FRONT     (V_FRONT),
        .SYNC      (V_SYNC),
        .BACK      (V_BACK),
        .POL       (VSYNC_POL),
        .CNT_WIDTH (V_CW)
    ) u_v_axis (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (!active),
        .step      (active && h_last_c),
        .cnt       (v_cnt),
        .last_c    (v_last_c),
        .visible_c (v_vis_c),
        .sync_c    (v_sync_c)
    );

    assign frame_end_c = active && h_last_c && v_last_c;
    assign de_c        = active && h_vis_c && v_vis_c;
    assign fs_c        = de_c && (h_cnt == '0) && (v_cnt == '0);
    assign le_c        = de_c && (32'(h_cnt) == H_VISIBLE - 1);

    // Run control. The counters go live one cycle after leaving IDLE, which
    // gives the two-edge enable-to-first-pixel latency. Leaving RUN/STOPPING
    // happens on the frame's last counter cycle and drops 'active' on the
    // same edge so the wrapped (0,0) position is never presented.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= IDLE;
            active <= 1'b0;
            busy   <= 1'b0;
        end else begin
            busy <= (state != IDLE);
            unique case (state)
                IDLE: begin
                    active <= 1'b0;
                    if (enable) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!enable && frame_end_c) begin
                        state  <= IDLE;
                        active <= 1'b0;
                    end else begin
                        active <= 1'b1;
                        if (!enable) begin
                            state <= STOPPING;
                        end
                    end
                end
                STOPPING: begin
                    if (enable) begin
                        state  <= RUN;
                        active <= 1'b1;
                    end else if (frame_end_c) begin
                        state  <= IDLE;
                        active <= 1'b0;
                    end else begin
                        active <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    active <= 1'b0;
                end
            endcase
        end
    end

    // Output registers: one cycle behind the counters
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_de    <= 1'b0;
            out_fs    <= 1'b0;
            out_le    <= 1'b0;
            out_hsync <= ~HSYNC_POL;
            out_vsync <= ~VSYNC_POL;
            out_x     <= '0;
            out_y     <= '0;
        end else begin
            out_de    <= de_c;
            out_fs    <= fs_c;
            out_le    <= le_c;
            out_hsync <= active ? h_sync_c : ~HSYNC_POL;
            out_vsync <= active ? v_sync_c : ~VSYNC_POL;
            out_x     <= de_c ? X_WIDTH'(h_cnt) : '0;
            out_y     <= de_c ? Y_WIDTH'(v_cnt) : '0;
        end
    end

`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
    // Frames started; advances on the same edge out_fs rises
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_frame_cnt <= '0;
        end else if (fs_c) begin
            out_frame_cnt <= out_frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: directed bench for video_timing_gen using a reduced
// timing set (17x12 frame) so whole frames, stops and restarts fit in a
// short run. vsync uses active-high polarity to exercise the POL parameter.
module tb_video_timing_gen;

    localparam int unsigned HV = 10, HF = 2, HS = 3, HB = 2;
    localparam int unsigned VV = 6,  VF = 1, VS = 2, VB = 3;
    localparam int unsigned HT = HV + HF + HS + HB;   // 17
    localparam int unsigned VT = VV + VF + VS + VB;   // 12
    localparam int unsigned FRAME = HT * VT;         // 204
    localparam int unsigned XW = 4, YW = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic          busy;
    logic          out_vsync;
    logic          out_hsync;
    logic          out_de;
    logic [XW-1:0] out_x;
    logic [YW-1:0] out_y;
    logic          out_fs;
    logic          out_le;
`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
    logic [15:0]   out_frame_cnt;
`endif

    int unsigned tests_run    = 0;
    int unsigned tests_failed = 0;
    int unsigned opos         = 0;   // frame position shown on the outputs
    int unsigned exp_frames   = 0;
    int unsigned de_seen, le_seen, fs_seen, hs_low, vs_high;

    always #5 clk = ~clk;

    video_timing_gen #(
        .H_VISIBLE (HV), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
        .V_VISIBLE (VV), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
        .HSYNC_POL (1'b0), .VSYNC_POL (1'b1),
        .X_WIDTH   (XW), .Y_WIDTH (YW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .busy      (busy),
        .out_vsync (out_vsync),
        .out_hsync (out_hsync),
        .out_de    (out_de),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_fs    (out_fs),
        .out_le    (out_le)
`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
        ,
        .out_frame_cnt (out_frame_cnt)
`endif
    );

    // Vector layout: {de, hsync, vsync, fs, le, x[3:0], y[2:0]}
    function automatic logic [11:0] exp_vec(input int unsigned pos, input bit run);
        int unsigned h, v;
        logic de, hs, vs, fs, le;
        logic [3:0] x;
        logic [2:0] y;
        h  = pos % HT;
        v  = pos / HT;
        de = run && (h < HV) && (v < VV);
        hs = (run && h >= HV + HF && h < HV + HF + HS) ? 1'b0 : 1'b1;
        vs = (run && v >= VV + VF && v < VV + VF + VS) ? 1'b1 : 1'b0;
        x  = de ? 4'(h) : 4'd0;
        y  = de ? 3'(v) : 3'd0;
        fs = de && (h == 0) && (v == 0);
        le = de && (h == HV - 1);
        return {de, hs, vs, fs, le, x, y};
    endfunction

    function automatic logic [11:0] obs_vec();
        return {out_de, out_hsync, out_vsync, out_fs, out_le, out_x, out_y};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance n cycles while running; every sample must match the position model
    task automatic scan(input string tag, input int unsigned n);
        int unsigned bad;
        int unsigned first_pos;
        logic [11:0] first_obs;
        logic [11:0] ev;
        bad       = 0;
        first_pos = 0;
        first_obs = '0;
        for (int unsigned i = 0; i < n; i++) begin
            step();
            opos = (opos + 1) % FRAME;
            ev   = exp_vec(opos, 1'b1);
            if (ev[8]) exp_frames++;
            if (out_de)     de_seen++;
            if (out_le)     le_seen++;
            if (out_fs)     fs_seen++;
            if (!out_hsync) hs_low++;
            if (out_vsync)  vs_high++;
            if (obs_vec() !== ev || busy !== 1'b1
`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
                || out_frame_cnt !== 16'(exp_frames)
`endif
            ) begin
                if (bad == 0) begin
                    first_pos = opos;
                    first_obs = obs_vec();
                end
                bad++;
            end
        end
        check($sformatf("%s mismatches (first at pos %0d obs 0x%0h exp 0x%0h)",
                        tag, first_pos, first_obs, exp_vec(first_pos, 1'b1)), bad, 32'd0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_vec"}, 32'(obs_vec()), 32'(exp_vec(0, 1'b0)));
    endtask

    // enable already high: fs/de two edges later, busy one edge later
    task automatic start_seq(input string tag);
        step();
        check({tag, "_e0_busy"}, 32'(busy), 32'd0);
        check({tag, "_e0_de"}, 32'(out_de), 32'd0);
        step();
        check({tag, "_e1_busy"}, 32'(busy), 32'd1);
        check({tag, "_e1_de"}, 32'(out_de), 32'd0);
        step();
        exp_frames++;
        check({tag, "_e2_vec"}, 32'(obs_vec()), 32'(exp_vec(0, 1'b1)));
        check({tag, "_e2_fs"}, 32'(out_fs), 32'd1);
        opos = 0;
    endtask

    initial begin
        reset_n = 1'b0;
        enable  = 1'b0;
        repeat (3) step();
        check_idle("reset");
`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
        check("reset_frame_cnt", 32'(out_frame_cnt), 32'd0);
`endif

        // Start, finish frame 1, then count one full frame
        reset_n = 1'b1;
        enable  = 1'b1;
        start_seq("start");
        scan("frame1", FRAME - 1);
        de_seen = 0; le_seen = 0; fs_seen = 0; hs_low = 0; vs_high = 0;
        scan("frame2", FRAME);
        check("frame_de_cycles", de_seen, HV * VV);
        check("frame_le_pulses", le_seen, VV);
        check("frame_fs_pulses", fs_seen, 32'd1);
        check("frame_hsync_low", hs_low, HS * VT);
        check("frame_vsync_high", vs_high, VS * HT);

        // Drop enable at line 3 pixel 5: frame must complete, then idle
        scan("to_stop_point", 3 * HT + 5 + 1);
        enable = 1'b0;
        scan("stopping", FRAME - 1 - opos);
        check("stop_last_pos", opos, FRAME - 1);
        step();
        check_idle("stopped");
        step();
        check_idle("stopped_hold");

        // Restart from idle, then re-enable while stopping
        enable = 1'b1;
        start_seq("restart");
        scan("pre_blip", 20);
        enable = 1'b0;
        scan("blip_stopping", 30);
        enable = 1'b1;
        scan("blip_resume", FRAME - opos);
        check("blip_next_fs", 32'(out_fs), 32'd1);

        // enable low exactly on the frame-wrap cycle
        scan("to_wrap", FRAME - 2);
        enable = 1'b0;
        scan("wrap_last", 1);
        step();
        check_idle("wrap_stop");
        step();
        check_idle("wrap_stop_hold");

        // Reset at line 2 pixel 4 while running
        enable = 1'b1;
        start_seq("run3");
        scan("to_reset_point", 2 * HT + 4);
        reset_n = 1'b0;
        step();
        check_idle("mid_reset");
        exp_frames = 0;
`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
        check("mid_reset_frame_cnt", 32'(out_frame_cnt), 32'd0);
`endif
        reset_n = 1'b1;
        start_seq("after_reset");
        scan("after_reset_frames", 3 * FRAME);
`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
        check("frame_cnt_after_3", 32'(out_frame_cnt), 32'd4);
`endif

        // Reset while stopping: stays idle afterwards with enable low
        enable = 1'b0;
        scan("stop_then_reset", 5);
        reset_n = 1'b0;
        step();
        check_idle("stopping_reset");
        reset_n = 1'b1;
        step();
        step();
        check_idle("stopping_reset_hold");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
